// File: rtl/core_io_pkg.sv
// rtl/core_io_pkg.sv - shared types and constants for the core byte-stream I/O controller
package core_io_pkg;

    typedef enum logic {
        IO_IDLE,
        IO_WAIT_IN
    } io_state_t;

    localparam int IO_BYTE_W     = 8;
    localparam int IO_WORD_BYTES = 4;

endpackage

// File: rtl/io_byte_fifo.sv
// rtl/io_byte_fifo.sv - byte FIFO with multi-byte push/pop; caller guarantees space and data
module io_byte_fifo
    import core_io_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int PUSH_W = 1,
    parameter int POP_W  = 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          push,
    input  logic [PUSH_W*IO_BYTE_W-1:0]   push_data,
    input  logic                          pop,
    output logic [POP_W*IO_BYTE_W-1:0]    pop_data,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          empty,
    output logic                          full
);

    localparam int AW = $clog2(DEPTH);

    logic [IO_BYTE_W-1:0] mem [DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(PUSH_W);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(POP_W);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < PUSH_W; i++)
                mem[wr_ptr[AW-1:0] + AW'(i)] <= push_data[i*IO_BYTE_W +: IO_BYTE_W];
        end
    end

    // Lowest byte lane of pop_data is the oldest entry.
    always_comb begin
        pop_data = '0;
        for (int i = 0; i < POP_W; i++)
            pop_data[i*IO_BYTE_W +: IO_BYTE_W] = mem[rd_ptr[AW-1:0] + AW'(i)];
    end

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/core_io_ctrl.sv
// rtl/core_io_ctrl.sv - core I/O port to UART byte stream bridge with RX word assembly and TX buffering
// Macro CORE_IO_OUT_WORD_EN: each core output pushes all 4 bytes (LSB first) instead of the low byte.
module core_io_ctrl
    import core_io_pkg::*;
#(
    parameter int RX_DEPTH = 256,
    parameter int TX_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        input_req,
    output logic [31:0] input_data,
    output logic        input_valid,
    input  logic [31:0] output_data,
    input  logic        output_valid,
    output logic        io_stall,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        rx_overrun,
    output logic        tx_overrun
);

    localparam int RXAW = $clog2(RX_DEPTH);
    localparam int TXAW = $clog2(TX_DEPTH);
`ifdef CORE_IO_OUT_WORD_EN
    localparam int OUT_BYTES = IO_WORD_BYTES;
`else
    localparam int OUT_BYTES = 1;
`endif

    io_state_t                     state;
    logic                          pop_flag;
    logic [RXAW:0]                 rx_count;
    logic                          rx_empty;
    logic                          rx_full;
    logic [IO_WORD_BYTES*8-1:0]    rx_word;
    logic                          rx_push;
    logic                          rx_pop;
    logic [TXAW:0]                 tx_count;
    logic                          tx_empty;
    logic                          tx_full;
    logic                          tx_nospace;
    logic                          tx_push;
    logic [OUT_BYTES*8-1:0]        tx_push_data;

`ifdef CORE_IO_OUT_WORD_EN
    assign tx_push_data = output_data;
`else
    logic unused_out_hi;
    assign unused_out_hi = ^output_data[31:8];
    assign tx_push_data  = output_data[7:0];
`endif

    assign rx_push    = rx_valid && !rx_full;
    assign rx_pop     = (state == IO_WAIT_IN) && !rx_empty &&
                        (rx_count >= (RXAW+1)'(IO_WORD_BYTES));
    assign tx_nospace = tx_full ||
                        (((TXAW+1)'(TX_DEPTH) - tx_count) < (TXAW+1)'(OUT_BYTES));
    // pop_flag is high only in the input_valid cycle, by which point the word is delivered,
    // so the stall window is exactly the WAIT_IN residency plus TX backpressure.
    assign io_stall   = (state == IO_WAIT_IN) | tx_nospace;
    assign tx_push    = output_valid && !io_stall;
    assign tx_valid   = !tx_empty;
    assign input_valid = pop_flag;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IO_IDLE;
            pop_flag   <= 1'b0;
            input_data <= '0;
            rx_overrun <= 1'b0;
            tx_overrun <= 1'b0;
        end else begin
            pop_flag <= rx_pop;
            case (state)
                IO_IDLE:    if (input_req) state <= IO_WAIT_IN;
                IO_WAIT_IN: if (rx_pop) begin
                    state      <= IO_IDLE;
                    input_data <= rx_word;
                end
                default:    state <= IO_IDLE;
            endcase
            if (rx_valid && rx_full)     rx_overrun <= 1'b1;
            if (output_valid && io_stall) tx_overrun <= 1'b1;
        end
    end

    io_byte_fifo #(
        .DEPTH  (RX_DEPTH),
        .PUSH_W (1),
        .POP_W  (IO_WORD_BYTES)
    ) u_rx_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (rx_push),
        .push_data (rx_data),
        .pop       (rx_pop),
        .pop_data  (rx_word),
        .count     (rx_count),
        .empty     (rx_empty),
        .full      (rx_full)
    );

    io_byte_fifo #(
        .DEPTH  (TX_DEPTH),
        .PUSH_W (OUT_BYTES),
        .POP_W  (1)
    ) u_tx_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (tx_push),
        .push_data (tx_push_data),
        .pop       (tx_valid && tx_ready),
        .pop_data  (tx_data),
        .count     (tx_count),
        .empty     (tx_empty),
        .full      (tx_full)
    );

endmodule

// File: tb/tb_core_io_ctrl.sv
// tb/tb_core_io_ctrl.sv - self-checking bench for core_io_ctrl
module tb_core_io_ctrl;

`ifdef CORE_IO_OUT_WORD_EN
    localparam int BPO = 4;
`else
    localparam int BPO = 1;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        input_req;
    logic [31:0] input_data;
    logic        input_valid;
    logic [31:0] output_data;
    logic        output_valid;
    logic        io_stall;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        rx_overrun;
    logic        tx_overrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  b [4];
        logic [31:0] word;
    } rd_vec_t;

    rd_vec_t vecs [5];

    always #5 clk = ~clk;

    core_io_ctrl dut (
        .clk          (clk),
        .rstn         (rstn),
        .input_req    (input_req),
        .input_data   (input_data),
        .input_valid  (input_valid),
        .output_data  (output_data),
        .output_valid (output_valid),
        .io_stall     (io_stall),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_overrun   (rx_overrun),
        .tx_overrun   (tx_overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic feed(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic read_word(input string name, input logic [31:0] exp);
        input_req = 1'b1;
        tick();
        input_req = 1'b0;
        chk({name, " stall_wait"}, io_stall, 1'b1);
        chk({name, " no_early"}, input_valid, 1'b0);
        tick();
        chk({name, " valid"}, input_valid, 1'b1);
        chk({name, " data"}, input_data, exp);
        chk({name, " stall_drop"}, io_stall, 1'b0);
        tick();
        chk({name, " valid_pulse"}, input_valid, 1'b0);
    endtask

    initial begin
        int          pushes;
        bit          seen;
        logic [31:0] od;

        vecs[0] = '{b: '{8'h78, 8'h56, 8'h34, 8'h12}, word: 32'h12345678};
        vecs[1] = '{b: '{8'h00, 8'h00, 8'h00, 8'h00}, word: 32'h00000000};
        vecs[2] = '{b: '{8'hFF, 8'hFF, 8'hFF, 8'hFF}, word: 32'hFFFFFFFF};
        vecs[3] = '{b: '{8'h01, 8'h02, 8'h03, 8'h04}, word: 32'h04030201};
        vecs[4] = '{b: '{8'hA5, 8'h5A, 8'hC3, 8'h3C}, word: 32'h3CC35AA5};

        rstn = 1'b0; input_req = 1'b0; output_data = '0; output_valid = 1'b0;
        rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        tick();
        chk("reset input_valid", input_valid, 1'b0);
        chk("reset input_data", input_data, 32'h0);
        chk("reset io_stall", io_stall, 1'b0);
        chk("reset tx_valid", tx_valid, 1'b0);
        chk("reset rx_overrun", rx_overrun, 1'b0);
        chk("reset tx_overrun", tx_overrun, 1'b0);

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 4; i++) feed(vecs[v].b[i]);
            read_word($sformatf("vec%0d", v), vecs[v].word);
        end

        // Request with RX empty, bytes trickle in later.
        input_req = 1'b1;
        tick();
        input_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("empty_req stall", io_stall, 1'b1);
            chk("empty_req no_strobe", input_valid, 1'b0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            chk("empty_req feed_stall", io_stall, 1'b1);
            chk("empty_req feed_no_strobe", input_valid, 1'b0);
            feed(8'hC0 + 8'(i));
        end
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (input_valid) begin
                seen = 1'b1;
                break;
            end
            chk("empty_req late_stall", io_stall, 1'b1);
            tick();
        end
        chk("empty_req strobe_seen", seen, 1'b1);
        chk("empty_req data", input_data, 32'hC3C2C1C0);
        chk("empty_req stall_drop", io_stall, 1'b0);
        tick();

        // TX backpressure fill and overrun.
        pushes = 0;
        for (int k = 0; k < 100; k++) begin
            if (io_stall) break;
            od = '0;
            for (int i = 0; i < 4; i++) od[i*8 +: 8] = 8'(BPO*k + i);
            output_valid = 1'b1;
            output_data  = od;
            tick();
            pushes++;
        end
        output_valid = 1'b0;
        chk("tx_fill pushes", pushes, 64 / BPO);
        chk("tx_fill stall", io_stall, 1'b1);
        chk("tx_fill no_overrun_yet", tx_overrun, 1'b0);
        output_valid = 1'b1;
        output_data  = 32'h99999999;
        tick();
        output_valid = 1'b0;
        chk("tx_overrun set", tx_overrun, 1'b1);
        tx_ready = 1'b1;
        for (int j = 0; j < 64; j++) begin
            chk("tx_drain valid", tx_valid, 1'b1);
            chk("tx_drain data", tx_data, 8'(j));
            tick();
        end
        chk("tx_drain empty", tx_valid, 1'b0);
        chk("tx_drain stall", io_stall, 1'b0);

`ifdef CORE_IO_OUT_WORD_EN
        begin
            logic [7:0] exp_b [4];
            exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
            tx_ready = 1'b0;
            output_valid = 1'b1;
            output_data  = 32'hDEADBEEF;
            tick();
            output_valid = 1'b0;
            tx_ready = 1'b1;
            for (int j = 0; j < 4; j++) begin
                chk("word_out valid", tx_valid, 1'b1);
                chk("word_out byte", tx_data, exp_b[j]);
                tick();
            end
            chk("word_out empty", tx_valid, 1'b0);
        end
`endif
        tx_ready = 1'b0;

        // RX fill to capacity, then one extra byte.
        for (int i = 0; i < 256; i++) feed(8'(i));
        chk("rx_fill no_overrun", rx_overrun, 1'b0);
        feed(8'hAA);
        chk("rx_overrun set", rx_overrun, 1'b1);
        read_word("rx_full_read", 32'h03020100);

        // Reset during WAIT_IN with partial RX data and pending TX.
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        feed(8'hE1);
        feed(8'hE2);
        output_valid = 1'b1;
        output_data  = 32'h5A;
        tick();
        output_valid = 1'b0;
        input_req = 1'b1;
        tick();
        input_req = 1'b0;
        chk("rst_mid stall_before", io_stall, 1'b1);
        chk("rst_mid tx_before", tx_valid, 1'b1);
        rstn = 1'b0;
        tick();
        chk("rst_mid stall", io_stall, 1'b0);
        chk("rst_mid tx_valid", tx_valid, 1'b0);
        chk("rst_mid rx_overrun", rx_overrun, 1'b0);
        chk("rst_mid tx_overrun", tx_overrun, 1'b0);
        chk("rst_mid input_data", input_data, 32'h0);
        rstn = 1'b1;
        tick();
        input_req = 1'b1;
        tick();
        input_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            feed(8'h11 * 8'(i + 1));
            chk("rst_mid partial_no_strobe", input_valid, 1'b0);
            chk("rst_mid partial_stall", io_stall, 1'b1);
        end
        feed(8'h44);
        chk("rst_mid fourth_no_strobe", input_valid, 1'b0);
        tick();
        chk("rst_mid fresh_valid", input_valid, 1'b1);
        chk("rst_mid fresh_data", input_data, 32'h44332211);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
